// File: rtl/mailbox_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mailbox_fifo
//  Purpose  : Parametrised first-word-fall-through FIFO. It extends the
//             single-word mailbox to DEPTH entries and adds an occupancy
//             count, full and almost-full flags, sticky overflow and
//             underflow flags, and a synchronous flush.
//  Revision : 1.0  initial release
// ============================================================================
module mailbox_fifo #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           w_data,
  input  logic                       w_en,
  output logic [WIDTH-1:0]           r_data,
  input  logic                       r_en,
  output logic                       d_available,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       flush,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);
  localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
  localparam logic [CW-1:0] c_af_level = CW'(AF_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          w_rd_acc;
  logic          w_wr_acc;

  // Pointers wrap explicitly so DEPTH does not have to be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == c_last_ptr) ? '0 : p + PW'(1);
  endfunction

  // Status is derived from the registered count alone.
  assign d_available = (count_q != '0);
  assign full        = (count_q == c_depth);
  assign almost_full = (count_q >= c_af_level);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  // The head word is visible with no read latency and reads as zero when empty.
  assign r_data = d_available ? mem_q[rd_ptr_q] : '0;

  // A pop needs data. A push needs room, or a slot freed by a pop in the
  // same cycle. Flush suppresses both.
  assign w_rd_acc = r_en & d_available & ~flush;
  assign w_wr_acc = w_en & (~full | w_rd_acc) & ~flush;

  // Next-state logic for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (w_rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (w_wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);

      case ({w_wr_acc, w_rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      if (r_en && !d_available) underflow_d = 1'b1;
      if (w_en && !w_wr_acc)    overflow_d  = 1'b1;
    end
  end

  // Control state register. Reset discards all queued data at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array. It has no reset because stale words are never exposed
  // while the count is zero.
  always_ff @(posedge clk) begin
    if (w_wr_acc) mem_q[wr_ptr_q] <= w_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_mailbox_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mailbox_fifo
//  Purpose  : Self-checking bench for mailbox_fifo (WIDTH=16, DEPTH=4,
//             AF_LEVEL=3). It runs directed scenarios followed by random
//             traffic. The reference model is a queue plus two error bits.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mailbox_fifo;

  localparam int WIDTH    = 16;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] w_data;
  logic             w_en;
  logic [WIDTH-1:0] r_data;
  logic             r_en;
  logic             d_available;
  logic             full;
  logic             almost_full;
  logic [2:0]       count;
  logic             flush;
  logic             overflow;
  logic             underflow;

  mailbox_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk), .rst_n(rst_n), .w_data(w_data), .w_en(w_en), .r_data(r_data),
    .r_en(r_en), .d_available(d_available), .full(full),
    .almost_full(almost_full), .count(count), .flush(flush),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue contents and sticky error bits.
  logic [WIDTH-1:0] ref_q [$];
  logic             ref_ovf;
  logic             ref_unf;
  // Scoreboard: every accepted write is expected to be popped later, in order.
  logic [WIDTH-1:0] exp_q [$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: at each falling edge, compare the DUT outputs with the model.
  // When the DUT presents a pop, check the popped word against the scoreboard.
  always @(negedge clk) begin
    check("count",       32'(count),       32'(ref_q.size()));
    check("d_available", 32'(d_available), 32'(ref_q.size() > 0));
    check("full",        32'(full),        32'(ref_q.size() == DEPTH));
    check("almost_full", 32'(almost_full), 32'(ref_q.size() >= AF_LEVEL));
    check("overflow",    32'(overflow),    32'(ref_ovf));
    check("underflow",   32'(underflow),   32'(ref_unf));
    check("r_data",      32'(r_data),      (ref_q.size() > 0) ? 32'(ref_q[0]) : 32'h0);
    if (rst_n && r_en && !flush && d_available) begin
      if (exp_q.size() == 0) check("pop_unexpected", 32'(d_available), 32'h0);
      else                   check("pop_data", 32'(r_data), 32'(exp_q.pop_front()));
    end
  end

  // Drive one cycle of stimulus, then advance the model by the spec rules.
  task automatic cycle(input logic we, input logic [WIDTH-1:0] wd,
                       input logic re, input logic fl);
    bit rd_ok;
    bit wr_ok;
    w_en = we; w_data = wd; r_en = re; flush = fl;
    @(posedge clk);
    if (fl) begin
      ref_q.delete(); exp_q.delete();
      ref_ovf = 1'b0; ref_unf = 1'b0;
    end else begin
      rd_ok = re && (ref_q.size() > 0);
      wr_ok = we && ((ref_q.size() < DEPTH) || rd_ok);
      if (re && !rd_ok) ref_unf = 1'b1;
      if (we && !wr_ok) ref_ovf = 1'b1;
      if (rd_ok) void'(ref_q.pop_front());
      if (wr_ok) begin
        ref_q.push_back(wd);
        exp_q.push_back(wd);
      end
    end
    #1;
  endtask

  initial begin
    ref_ovf = 1'b0; ref_unf = 1'b0;
    rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; flush = 1'b0; w_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset.
    repeat (2) cycle(0, 16'h0, 0, 0);

    // Fill to full, then write once more to provoke an overflow.
    for (int i = 1; i <= 5; i++) cycle(1, 16'hA000 + 16'(i), 0, 0);
    // Drain, then issue one extra read to provoke an underflow.
    for (int i = 0; i < 5; i++) cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 0, 0);

    // Wrap: interleaved writes and reads walk the pointers past index 3.
    cycle(0, 16'h0, 0, 1);
    cycle(1, 16'hB000, 0, 0);
    for (int i = 1; i < 6; i++) cycle(1, 16'hB000 + 16'(i), 1, 0);
    cycle(0, 16'h0, 1, 0);

    // Simultaneous write and read while full.
    for (int i = 0; i < 4; i++) cycle(1, 16'hC000 + 16'(i), 0, 0);
    cycle(1, 16'hC004, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 16'h0, 1, 0);
    // Simultaneous write and read while empty.
    cycle(1, 16'hD000, 1, 0);
    cycle(0, 16'h0, 0, 0);
    cycle(0, 16'h0, 1, 0);

    // Flush with count=3 and both error flags set.
    for (int i = 0; i < 5; i++) cycle(1, 16'hE000 + 16'(i), 0, 0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 0, 1);
    cycle(0, 16'h0, 0, 0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) cycle(1, 16'hF000 + 16'(i), 0, 0);
    w_en = 1'b0;
    #1 rst_n = 1'b0;
    ref_q.delete(); exp_q.delete();
    ref_ovf = 1'b0; ref_unf = 1'b0;
    #1;
    check("async_rst_count",  32'(count),       32'h0);
    check("async_rst_davail", 32'(d_available), 32'h0);
    check("async_rst_rdata",  32'(r_data),      32'h0);
    check("async_rst_full",   32'(full),        32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(0, 16'h0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) < 60), 16'($urandom()),
            ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 2));
    end
    cycle(0, 16'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mailbox_fifo.md
Name: mailbox_fifo

Overview:
- Parametrised synchronous FIFO that generalises the single-entry mailbox (one `w_data`/`r_data` word plus `d_available`) to DEPTH entries of WIDTH bits.
- Adds occupancy count, full and almost-full flags, sticky overflow/underflow error flags, and a synchronous flush.
- Sits between the sticker/colour capture logic (writer) and the cube-state assembler (reader), both in the single system clock domain.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 8, number of storage entries (>=2; power of two not required)
AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL (1..DEPTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
w_data  input  WIDTH  write data
w_en  input  1  write request, sampled on clk rising edge (level, one word per cycle)
r_data  output  WIDTH  head-of-queue word (first-word-fall-through); all zeros when empty
r_en  input  1  read/pop request, sampled on clk rising edge
d_available  output  1  high when count > 0
full  output  1  high when count == DEPTH
almost_full  output  1  high when count >= AF_LEVEL
count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
flush  input  1  synchronous clear of contents and error flags
overflow  output  1  sticky: a write was dropped because full
underflow  output  1  sticky: a read was issued while empty

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr, count = 0.
  - d_available, full, almost_full, overflow, underflow = 0.
  - r_data = 0.
  - Storage contents need not be cleared.
  - Reset mid-operation discards all queued data immediately.
- Pointers advance by 1 per accepted operation and wrap from DEPTH-1 to 0.
- Count tracking is explicit, not derived from pointer difference, so non-power-of-two DEPTH works.
- Accepted write (w_en & (!full | r_en_accepted)):
  - mem[wr_ptr] <= w_data; wr_ptr advances.
- Accepted read (r_en & d_available):
  - rd_ptr advances.
  - The word popped is the r_data value visible in the same cycle (zero read latency, FWFT).
- Next count:
  - count+1 on write only.
  - count-1 on read only.
  - unchanged on both or neither.
- Simultaneous w_en and r_en:
  - Non-empty, non-full: both accepted, count unchanged.
  - Full: read accepted, so the write is also accepted (slot freed same cycle), count stays DEPTH, no overflow.
  - Empty: read rejected (underflow set), write accepted, count becomes 1. The written word does not bypass to r_data in that cycle; it appears on r_data the cycle after.
- Write while full without r_en:
  - Data dropped, state unchanged, overflow <= 1.
- Read while empty:
  - No pointer change, underflow <= 1.
- overflow and underflow stay set until flush or reset.
- flush (synchronous, highest priority after reset):
  - Pointers, count, overflow and underflow cleared next edge.
  - w_en and r_en in the same cycle are ignored and set no error flags.
- Output derivation:
  - All status outputs (d_available, full, almost_full, count) are derived combinationally from registered count.
  - r_data = d_available ? mem[rd_ptr] : 0.
- Timing: write-to-visible latency is 1 cycle. A word written at edge N is on r_data and d_available is high after edge N.

Test Plan:
- Reset then idle, WIDTH=16, DEPTH=4, AF_LEVEL=3 -> count=0, d_available=0, r_data=16'h0000, all flags 0.
- Write 16'hA001, A002, A003, A004 on consecutive cycles:
  - count reads 1,2,3,4; almost_full rises at count 3; full at 4.
  - r_data=16'hA001 throughout.
  - A fifth write of 16'hA005 sets overflow=1 and leaves count=4.
- From full, pop 4 words -> r_data sequence A001, A002, A003, A004, then 0000 with d_available=0. One extra r_en sets underflow=1 and count stays 0.
- Wrap test:
  - Write 6 and read 6 interleaved so pointers pass index 3→0.
  - Data order is preserved (B000..B005 read back in order) and count never exceeds 2.
- Simultaneous w_en+r_en:
  - When full (count=4): count stays 4, head advances, new word read back last, overflow stays 0.
  - When empty: count becomes 1, underflow=1, new word on r_data the next cycle.
- Flush and reset:
  - flush with count=3, overflow=1, underflow=1 -> next cycle count=0, all flags 0, r_data=0.
  - rst_n pulsed low mid-burst -> outputs clear immediately without waiting for a clock edge.
